sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering AXI channel payloads inside the crossbar where both sides share one clock domain. It generalises the team's dual-clock FIFO with an occupancy count, programmable almost-full/almost-empty thresholds, and a selectable standard/first-word-fall-through read mode. It also adds sticky overflow/underflow error flags and a synchronous flush. Storage is an internal register array of 2^ADDR_SIZE entries.

---
 rtl/sync_fifo_if.sv | 29 ++
 rtl/sync_fifo.sv | 116 +++++++++++
 tb/tb_sync_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo: the producer/consumer side
// drives through master, the FIFO itself sits on slave.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 4
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_SIZE:0]    level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow, synchronous flush and optional FWFT read mode.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_SIZE) - 2,
    parameter int AE_THRESH  = 2
) (
    input logic        clk,
    input logic        rstn,
    sync_fifo_if.slave fifo
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0]   LVL_FULL = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0]   LVL_AF   = (ADDR_SIZE+1)'(AF_THRESH);
    localparam logic [ADDR_SIZE:0]   LVL_AE   = (ADDR_SIZE+1)'(AE_THRESH);
    localparam logic [ADDR_SIZE:0]   LVL_ONE  = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]    level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic full;
    logic empty;
    logic wr_accept;
    logic rd_accept;

    // Flags come only from the registered level, never from the requests.
    always_comb begin
        full      = (level_q == LVL_FULL);
        empty     = (level_q == '0);
        wr_accept = fifo.wr_en && !full  && !fifo.flush;
        rd_accept = fifo.rd_en && !empty && !fifo.flush;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dout_d      = dout_q;

        if (fifo.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            dout_d      = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = mem_q[rd_ptr_q];
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            overflow_d  = overflow_q  | (fifo.wr_en && full);
            underflow_d = underflow_q | (fifo.rd_en && empty);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

    // Storage is deliberately unreset; flush and reset only move pointers.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= fifo.din;
        end
    end

    always_comb begin
        if (FWFT != 0) begin
            fifo.dout = empty ? '0 : mem_q[rd_ptr_q];
        end else begin
            fifo.dout = dout_q;
        end
    end

    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.almost_full  = (level_q >= LVL_AF);
    assign fifo.almost_empty = (level_q <= LVL_AE);
    assign fifo.level        = level_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode and an FWFT instance,
// both DEPTH 4, AF_THRESH 3, AE_THRESH 1.
module tb_sync_fifo;
    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    sync_fifo_if #(.DATA_WIDTH(16), .ADDR_SIZE(2)) s_if ();
    sync_fifo_if #(.DATA_WIDTH(16), .ADDR_SIZE(2)) f_if ();

    sync_fifo #(
        .DATA_WIDTH(16), .ADDR_SIZE(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
    ) u_std (
        .clk(clk), .rstn(rstn), .fifo(s_if)
    );

    sync_fifo #(
        .DATA_WIDTH(16), .ADDR_SIZE(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
    ) u_fwft (
        .clk(clk), .rstn(rstn), .fifo(f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are observed there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.din = '0;
        f_if.flush = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.din = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        #2;
        n_checks++;
        if (s_if.level !== 3'd0 || s_if.empty !== 1'b1 || s_if.full !== 1'b0 ||
            s_if.almost_empty !== 1'b1 || s_if.almost_full !== 1'b0 ||
            s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0 || s_if.dout !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_std: lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b dout=%h, need 0 1 0 1 0 0 0 0000",
                     s_if.level, s_if.empty, s_if.full, s_if.almost_empty, s_if.almost_full,
                     s_if.overflow, s_if.underflow, s_if.dout);
        end
        n_checks++;
        if (f_if.level !== 3'd0 || f_if.empty !== 1'b1 || f_if.dout !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_fwft: lvl=%0d e=%b dout=%h, need 0 1 0000", f_if.level, f_if.empty, f_if.dout);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [2:0] exp_lvl [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic       exp_ae  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_ful [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 16'h00A1 + 16'(i);
            tick();
            n_checks++;
            if (s_if.level !== exp_lvl[i] || s_if.almost_empty !== exp_ae[i] ||
                s_if.almost_full !== exp_af[i] || s_if.full !== exp_ful[i] || s_if.overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d: lvl=%0d ae=%b af=%b f=%b ov=%b, need %0d %b %b %b 0", i,
                         s_if.level, s_if.almost_empty, s_if.almost_full, s_if.full, s_if.overflow,
                         exp_lvl[i], exp_ae[i], exp_af[i], exp_ful[i]);
            end
        end
        s_if.din = 16'h00FF;
        tick();
        n_checks++;
        if (s_if.level !== 3'd4 || s_if.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: lvl=%0d ov=%b, need 4 1", s_if.level, s_if.overflow);
        end
        s_if.wr_en = 1'b0;
        tick();
        n_checks++;
        if (s_if.overflow !== 1'b1 || s_if.level !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_sticky: ov=%b lvl=%0d, need 1 4", s_if.overflow, s_if.level);
        end
    endtask

    task automatic test_drain_std();
        for (int i = 0; i < 4; i++) begin
            s_if.rd_en = 1'b1;
            tick();
            n_checks++;
            if (s_if.dout !== 16'h00A1 + 16'(i) || s_if.level !== 3'(3 - i)) begin
                n_fail++;
                $display("FAIL drain_%0d: dout=%h lvl=%0d, need %h %0d", i, s_if.dout, s_if.level,
                         16'h00A1 + 16'(i), 3 - i);
            end
        end
        n_checks++;
        if (s_if.empty !== 1'b1 || s_if.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: e=%b un=%b, need 1 0", s_if.empty, s_if.underflow);
        end
        tick();
        n_checks++;
        if (s_if.underflow !== 1'b1 || s_if.dout !== 16'h00A4 || s_if.level !== 3'd0) begin
            n_fail++;
            $display("FAIL underflow_set: un=%b dout=%h lvl=%0d, need 1 00a4 0", s_if.underflow, s_if.dout, s_if.level);
        end
        s_if.rd_en = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 16'h0B00 + 16'(i);
            tick();
        end
        n_checks++;
        if (s_if.level !== 3'd3 || s_if.overflow !== 1'b1 || s_if.underflow !== 1'b1 || s_if.dout !== 16'h00A4) begin
            n_fail++;
            $display("FAIL preflush: lvl=%0d ov=%b un=%b dout=%h, need 3 1 1 00a4",
                     s_if.level, s_if.overflow, s_if.underflow, s_if.dout);
        end
        s_if.flush = 1'b1;
        s_if.rd_en = 1'b1;
        tick();
        s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        n_checks++;
        if (s_if.level !== 3'd0 || s_if.empty !== 1'b1 || s_if.overflow !== 1'b0 ||
            s_if.underflow !== 1'b0 || s_if.dout !== 16'h0) begin
            n_fail++;
            $display("FAIL flush: lvl=%0d e=%b ov=%b un=%b dout=%h, need 0 1 0 0 0000",
                     s_if.level, s_if.empty, s_if.overflow, s_if.underflow, s_if.dout);
        end
    endtask

    task automatic test_back_to_back();
        s_if.wr_en = 1'b1;
        s_if.din = 16'h0010; tick();
        s_if.din = 16'h0011; tick();
        s_if.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_if.din = 16'h0012 + 16'(i);
            tick();
            n_checks++;
            if (s_if.level !== 3'd2 || s_if.dout !== 16'h0010 + 16'(i)) begin
                n_fail++;
                $display("FAIL b2b_%0d: lvl=%0d dout=%h, need 2 %h", i, s_if.level, s_if.dout, 16'h0010 + 16'(i));
            end
        end
        s_if.rd_en = 1'b0;
        s_if.din = 16'h001C; tick();
        s_if.din = 16'h001D; tick();
        s_if.wr_en = 1'b0;
    endtask

    task automatic test_simul_boundaries();
        logic [15:0] exp_d [3] = '{16'h001B, 16'h001C, 16'h001D};
        n_checks++;
        if (s_if.full !== 1'b1 || s_if.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL prefull: f=%b ov=%b, need 1 0", s_if.full, s_if.overflow);
        end
        s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.din = 16'h00EE;
        tick();
        s_if.wr_en = 1'b0;
        n_checks++;
        if (s_if.level !== 3'd3 || s_if.overflow !== 1'b1 || s_if.dout !== 16'h001A) begin
            n_fail++;
            $display("FAIL rw_full: lvl=%0d ov=%b dout=%h, need 3 1 001a", s_if.level, s_if.overflow, s_if.dout);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (s_if.dout !== exp_d[i]) begin
                n_fail++;
                $display("FAIL rw_full_drain_%0d: dout=%h, need %h", i, s_if.dout, exp_d[i]);
            end
        end
        s_if.wr_en = 1'b1; s_if.din = 16'h0077;
        tick();
        s_if.wr_en = 1'b0;
        n_checks++;
        if (s_if.level !== 3'd1 || s_if.underflow !== 1'b1 || s_if.dout !== 16'h001D) begin
            n_fail++;
            $display("FAIL rw_empty: lvl=%0d un=%b dout=%h, need 1 1 001d", s_if.level, s_if.underflow, s_if.dout);
        end
        tick();
        s_if.rd_en = 1'b0;
        n_checks++;
        if (s_if.dout !== 16'h0077 || s_if.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_empty_word: dout=%h e=%b, need 0077 1", s_if.dout, s_if.empty);
        end
    endtask

    task automatic test_fwft();
        f_if.wr_en = 1'b1; f_if.din = 16'h0055;
        tick();
        f_if.wr_en = 1'b0;
        n_checks++;
        if (f_if.empty !== 1'b0 || f_if.dout !== 16'h0055) begin
            n_fail++;
            $display("FAIL fwft_first: e=%b dout=%h, need 0 0055", f_if.empty, f_if.dout);
        end
        tick();
        n_checks++;
        if (f_if.dout !== 16'h0055 || f_if.level !== 3'd1) begin
            n_fail++;
            $display("FAIL fwft_hold: dout=%h lvl=%0d, need 0055 1", f_if.dout, f_if.level);
        end
        f_if.rd_en = 1'b1;
        tick();
        f_if.rd_en = 1'b0;
        n_checks++;
        if (f_if.empty !== 1'b1 || f_if.dout !== 16'h0) begin
            n_fail++;
            $display("FAIL fwft_read: e=%b dout=%h, need 1 0000", f_if.empty, f_if.dout);
        end
        f_if.wr_en = 1'b1;
        f_if.din = 16'h0061; tick();
        f_if.din = 16'h0062; tick();
        f_if.wr_en = 1'b0;
        n_checks++;
        if (f_if.dout !== 16'h0061 || f_if.level !== 3'd2) begin
            n_fail++;
            $display("FAIL fwft_order0: dout=%h lvl=%0d, need 0061 2", f_if.dout, f_if.level);
        end
        f_if.rd_en = 1'b1;
        tick();
        f_if.rd_en = 1'b0;
        n_checks++;
        if (f_if.dout !== 16'h0062 || f_if.level !== 3'd1) begin
            n_fail++;
            $display("FAIL fwft_order1: dout=%h lvl=%0d, need 0062 1", f_if.dout, f_if.level);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill();
        test_drain_std();
        test_flush();
        test_back_to_back();
        test_simul_boundaries();
        test_fwft();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
